// File: rtl/fft_buffer_pkg.sv
// Shared types for the FFT frame buffer: write FSM states, bank states and the
// point-index bit reversal used by the FFT_FRAME_BUFFER_BITREV_EN build.
package fft_buffer_pkg;

  typedef enum logic [1:0] {IDLE, RECEIVING, DRAIN} wr_state_e;
  typedef enum logic       {FREE, FULL}             bank_state_e;

  // Reverses the low nfft bits of idx; bits at or above nfft come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int nfft);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < nfft) r[nfft-1-i] = idx[i];
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One ping-pong bank: a whole point {IM, RE} is written per edge as an element
// pair, and one element is read asynchronously by element address.
module fft_bank_ram #(
  parameter int NFFT               = 3,
  parameter int DATA_WIDTH         = 32,
  parameter int N_ELEMENTS         = 2 * (2 ** NFFT),
  parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [NFFT-1:0]               wr_pt,
  input  logic [2*DATA_WIDTH-1:0]       wr_data,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] mem [N_ELEMENTS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_pt, 1'b0}] <= wr_data[DATA_WIDTH-1:0];
      mem[{wr_pt, 1'b1}] <= wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong AXIS capture of complex FFT frames with length checking and reader release.
// Define FFT_FRAME_BUFFER_BITREV_EN to store bit-reversed FFT output in natural order.
module fft_frame_buffer
  import fft_buffer_pkg::*;
#(
  parameter int NFFT               = 3,
  parameter int DATA_WIDTH         = 32,
  parameter int POINT_SIZE         = 2 ** NFFT,
  parameter int N_ELEMENTS         = 2 * POINT_SIZE,
  parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          s_tready,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  input  logic [2*DATA_WIDTH-1:0]       s_tdata,
  output logic                          rd_valid,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_release,
  output logic                          rd_err_short,
  output logic                          rd_err_long,
  output logic                          received
);

  localparam logic [NFFT:0] PS_C   = (NFFT+1)'(POINT_SIZE);
  localparam logic [NFFT:0] LAST_C = (NFFT+1)'(POINT_SIZE - 1);

  wr_state_e              st, st_nx;
  bank_state_e [1:0]      bank_st;
  logic [1:0]             bank_short, bank_long;
  logic                   wptr, rptr;
  logic [NFFT:0]          cnt, cnt_nx, idx;
  logic [NFFT-1:0]        wr_pt;
  logic                   wr_en, commit, commit_short, commit_long, rel;
  logic [1:0][DATA_WIDTH-1:0] bank_rd;

`ifdef FFT_FRAME_BUFFER_BITREV_EN
  logic [15:0] idx_br;
  always_comb begin
    idx_br = bitrev({{(15-NFFT){1'b0}}, idx}, NFFT);
    wr_pt  = idx_br[NFFT-1:0];
  end
`else
  assign wr_pt = idx[NFFT-1:0];
`endif

  // Index of the beat currently on the bus; a fresh frame always starts at 0.
  always_comb begin
    st_nx        = st;
    cnt_nx       = cnt;
    s_tready     = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;
    commit_short = 1'b0;
    commit_long  = 1'b0;
    idx          = (st == IDLE) ? '0 : cnt;
    case (st)
      IDLE:    s_tready = (bank_st[wptr] == FREE);
      default: s_tready = 1'b1;
    endcase
    if (reset) s_tready = 1'b0;
    if (s_tvalid && s_tready) begin
      if (st == DRAIN || idx == PS_C) begin
        if (s_tlast) begin
          commit      = 1'b1;
          commit_long = 1'b1;
          st_nx       = IDLE;
          cnt_nx      = '0;
        end else begin
          st_nx = DRAIN;
        end
      end else begin
        wr_en = 1'b1;
        if (s_tlast) begin
          commit       = 1'b1;
          commit_short = (idx != LAST_C);
          st_nx        = IDLE;
          cnt_nx       = '0;
        end else begin
          st_nx  = RECEIVING;
          cnt_nx = idx + 1'b1;
        end
      end
    end
  end

  assign rd_valid     = (bank_st[rptr] == FULL);
  assign rel          = rd_release & rd_valid;
  assign rd_err_short = bank_short[rptr];
  assign rd_err_long  = bank_long[rptr];
  assign rd_data      = bank_rd[rptr];

  // Release and commit can share an edge; they always target different banks.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      cnt        <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      bank_short <= '0;
      bank_long  <= '0;
      received   <= 1'b0;
      for (int b = 0; b < 2; b++) bank_st[b] <= FREE;
    end else begin
      st       <= st_nx;
      cnt      <= cnt_nx;
      received <= commit;
      if (rel) begin
        bank_st[rptr]    <= FREE;
        bank_short[rptr] <= 1'b0;
        bank_long[rptr]  <= 1'b0;
        rptr             <= ~rptr;
      end
      if (commit) begin
        bank_st[wptr]    <= FULL;
        bank_short[wptr] <= commit_short;
        bank_long[wptr]  <= commit_long;
        wptr             <= ~wptr;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bank_ram #(
      .NFFT               (NFFT),
      .DATA_WIDTH         (DATA_WIDTH),
      .N_ELEMENTS         (N_ELEMENTS),
      .ELEMENTS_ADDR_SIZE (ELEMENTS_ADDR_SIZE)
    ) u_ram (
      .clk     (clk),
      .we      (wr_en && (wptr == 1'(b))),
      .wr_pt   (wr_pt),
      .wr_data (s_tdata),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
AXI-Stream slave that captures complex FFT output frames into a two-bank (ping-pong) RAM. The host reads one bank through an asynchronous element-addressed port while the next frame streams into the other bank. It is the parametrised successor of the single-bank FFT output capture. It adds configurable width, frame-length checking, back-pressure when both banks are full, and explicit buffer release by the reader.

Parameters:
NFFT, 3, log2 of FFT points per frame
DATA_WIDTH, 32, bits per RE or IM component
POINT_SIZE, 2**NFFT, points per frame (derived)
N_ELEMENTS, 2*POINT_SIZE, RE/IM elements per bank (derived)
ELEMENTS_ADDR_SIZE, clog2(N_ELEMENTS), element address width (derived)

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
s_tready  out  1  AXIS ready
s_tvalid  in  1  AXIS valid
s_tlast  in  1  AXIS last beat of frame
s_tdata  in  2*DATA_WIDTH  {IM, RE}
rd_valid  out  1  a committed frame is readable
rd_addr  in  ELEMENTS_ADDR_SIZE  element address; even = RE, odd = IM
rd_data  out  DATA_WIDTH  combinational read of the read bank at rd_addr
rd_release  in  1  one-cycle pulse; frees the current read bank
rd_err_short  out  1  readable frame ended (tlast) before POINT_SIZE beats
rd_err_long  out  1  readable frame carried more than POINT_SIZE beats
received  out  1  one-cycle pulse when a frame is committed

Behaviour:
- Reset (one clk edge with reset=1):
  - s_tready=0, received=0, rd_valid=0, error flags 0.
  - Both banks FREE; write and read bank pointers 0; beat counter 0.
  - A partial frame is discarded. RAM contents are undefined.
- Bank state: each bank is FREE or FULL, with per-bank short/long flags. Banks are used strictly in order; the read pointer follows the write pointer.
- Write FSM states: IDLE, RECEIVING, DRAIN.
- IDLE:
  - s_tready=1 only if the write bank is FREE; otherwise 0 (back-pressure).
  - A handshake (tvalid & tready) stores the beat as index 0 and moves to RECEIVING. If that beat also has tlast, the frame commits immediately.
- RECEIVING:
  - s_tready=1.
  - Beat at index i: RE written to element 2i, IM written to element 2i+1, at the handshake edge.
- Commit (tlast beat accepted):
  - Write bank marked FULL; write pointer toggles; FSM returns to IDLE; received=1 on the following cycle.
  - short flag = (beat count < POINT_SIZE). Unwritten elements keep stale data.
- Over-length: a beat at i = POINT_SIZE without tlast enters DRAIN.
- DRAIN:
  - s_tready=1; beats are discarded.
  - On tlast: commit with the long flag set.
- Read side:
  - rd_valid = read bank FULL. rd_err_* reflect the read bank's flags.
  - rd_data is combinational, zero latency. When rd_valid=0, rd_data is don't-care.
- rd_release:
  - With rd_valid=1: read bank → FREE, read pointer toggles, flags cleared.
  - With rd_valid=0: ignored.
- Simultaneous commit and release on the same edge: both take effect.
  - When both banks were FULL, commit cannot occur (tready=0), so there is no conflict.
  - If the released bank is the next write bank, s_tready may rise the cycle after the release.
- Back-to-back frames: a new frame may start the cycle after commit if the other bank is FREE. No dead cycle is required beyond IDLE re-entry.
- Beat counter width is NFFT+1 so POINT_SIZE is representable without wrap.

Optional Feature:
FFT_FRAME_BUFFER_BITREV_EN
- Defined: the write point index is bit-reversed over NFFT bits before element addressing. Bit-reversed FFT output is then stored in natural order; rd_addr semantics are unchanged.
- Undefined: the index is used as received.
- DRAIN and error behaviour are identical in both builds.

Decomposition:
- Package fft_buffer_pkg:
  - write FSM state enum (IDLE, RECEIVING, DRAIN)
  - bank state enum (FREE, FULL)
  - function bitrev(idx, NFFT)
- Sub-module fft_bank_ram: single-write-port, async-read RAM of N_ELEMENTS x DATA_WIDTH. Instantiated twice, with the read mux at top level.

Test Plan:
- NFFT=3, 8 beats, RE=k, IM=100+k, tlast on beat 7 → received pulse once; rd_valid=1; rd_addr 0..15 returns 0,100,1,101..7,107; both error flags 0.
- Two frames back-to-back with no release → second frame accepted into bank 1. A third frame sees s_tready=0 until rd_release. After release, rd_data shows frame 2.
- tlast on beat 4 → rd_err_short=1, elements 0..9 valid. 11 beats with tlast on beat 10 → rd_err_long=1, elements match beats 0..7, beats 8..10 dropped.
- Reset asserted after 3 beats → s_tready=0 next cycle; rd_valid=0. A full frame afterwards lands in bank 0 correctly.
- rd_release on the same edge as a commit into the other bank → rd_valid stays 1 and shows the new frame; no frame lost.
- BITREV_EN build, beats with RE=k → rd_addr 2*bitrev(k) returns k (beat 1 at element 8, beat 3 at element 12).
